// File: rtl/arb_reg4_pkg.sv
// Shared definitions for the two-requester arbitrated 4-bit register.
//   state_t  : 2-bit FSM encoding (IDLE, GRANT, ACK, LOCK)
//   LOCK_W   : width of the post-write lock down-counter
//   onehot2  : index -> one-hot select for a two-entry vector
package arb_reg4_pkg;

    localparam int LOCK_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2,
        ST_LOCK  = 2'd3
    } state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/reg4_ffd.sv
// Four D flip-flops with load enable and asynchronous active-low clear.
//   clk   : rising-edge clock
//   rst_n : asynchronous clear, active low
//   en    : load enable; q holds when low
//   d     : 4-bit data in
//   q     : 4-bit stored value
module reg4_ffd (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] d,
    output logic [3:0] q
);

    // NOTE: clocked state is assigned with <= so every flop samples the
    // pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 4'h0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/arb_reg4_ctrl.sv
// Round-robin arbiter giving two requesters write access to one shared
// 4-bit register. Each write runs IDLE -> GRANT -> ACK -> LOCK x LOCK_CYC
// -> IDLE; arbitration happens only in IDLE.
//   sclk    : rising-edge clock
//   srst_n  : asynchronous reset, active low
//   sReq    : level write requests, bit i from requester i
//   sDat0/1 : write data from requester 0 / 1
//   sGnt    : one-hot grant, high during GRANT
//   sAck    : one-hot write-complete pulse, high during ACK
//   sQ      : shared register contents
//   sOwner  : index of the requester that performed the last write
//   sBusy   : high whenever the FSM is not in IDLE
module arb_reg4_ctrl
    import arb_reg4_pkg::*;
#(
    parameter int LOCK_CYC = 2
) (
    input  logic       sclk,
    input  logic       srst_n,
    input  logic [1:0] sReq,
    input  logic [3:0] sDat0,
    input  logic [3:0] sDat1,
    output logic [1:0] sGnt,
    output logic [1:0] sAck,
    output logic [3:0] sQ,
    output logic       sOwner,
    output logic       sBusy
);

    // The counter holds "LOCK cycles remaining after this one", so the
    // value loaded on ACK exit is one less than the lock length.
    localparam logic [LOCK_W-1:0] LOCK_LOAD =
        LOCK_W'((LOCK_CYC > 0) ? (LOCK_CYC - 1) : 0);

    state_t              state_q, state_d;
    logic                winner_q, winner_d;
    logic                fav_q, fav_d;      // requester favoured on a tie
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic                owner_q;
    logic                load_en;
    logic [3:0]          wr_data;

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state_q    <= ST_IDLE;
            winner_q   <= 1'b0;
            fav_q      <= 1'b0;
            lock_cnt_q <= '0;
            owner_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            winner_q   <= winner_d;
            fav_q      <= fav_d;
            lock_cnt_q <= lock_cnt_d;
            if (load_en) begin
                owner_q <= winner_q;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        fav_d      = fav_q;
        lock_cnt_d = lock_cnt_q;
        load_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|sReq) begin
                    // Tie goes to the favoured requester; otherwise the
                    // sole requester wins.
                    winner_d = (&sReq) ? fav_q : sReq[1];
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                load_en = 1'b1;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                // The grant has completed: favour the other requester next.
                fav_d = ~winner_q;
                if (LOCK_CYC == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d    = ST_LOCK;
                    lock_cnt_d = LOCK_LOAD;
                end
            end
            ST_LOCK: begin
                if (lock_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q - LOCK_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wr_data = winner_q ? sDat1 : sDat0;

    reg4_ffd u_reg (
        .clk   (sclk),
        .rst_n (srst_n),
        .en    (load_en),
        .d     (wr_data),
        .q     (sQ)
    );

    // Outputs decode from registered state and winner only.
    assign sGnt   = (state_q == ST_GRANT) ? onehot2(winner_q) : 2'b00;
    assign sAck   = (state_q == ST_ACK)   ? onehot2(winner_q) : 2'b00;
    assign sBusy  = (state_q != ST_IDLE);
    assign sOwner = owner_q;

endmodule

// File: tb/tb_arb_reg4_ctrl.sv
// Self-checking bench for arb_reg4_ctrl. Two instances share the stimulus:
// dut_a with the default lock length (2) and dut_b with LOCK_CYC = 0.
module tb_arb_reg4_ctrl;

    logic       sclk   = 1'b0;
    logic       srst_n = 1'b0;
    logic [1:0] sReq   = 2'b00;
    logic [3:0] sDat0  = 4'h0;
    logic [3:0] sDat1  = 4'h0;

    logic [1:0] a_gnt, a_ack, b_gnt, b_ack;
    logic [3:0] a_q, b_q;
    logic       a_owner, a_busy, b_owner, b_busy;

    int checks = 0;
    int errors = 0;

    always #5 sclk = ~sclk;

    arb_reg4_ctrl dut_a (
        .sclk(sclk), .srst_n(srst_n), .sReq(sReq), .sDat0(sDat0), .sDat1(sDat1),
        .sGnt(a_gnt), .sAck(a_ack), .sQ(a_q), .sOwner(a_owner), .sBusy(a_busy)
    );

    arb_reg4_ctrl #(.LOCK_CYC(0)) dut_b (
        .sclk(sclk), .srst_n(srst_n), .sReq(sReq), .sDat0(sDat0), .sDat1(sDat1),
        .sGnt(b_gnt), .sAck(b_ack), .sQ(b_q), .sOwner(b_owner), .sBusy(b_busy)
    );

    // ------------------------------------------------------------------
    // Reference model: each write is a transaction whose age counts cycles
    // since it was granted. Age 1 = grant cycle, age 2 = ack cycle, ages
    // 3..2+L = lock cycles, age 0 = idle.
    // ------------------------------------------------------------------
    int         m_lock [2] = '{2, 0};
    int         m_age  [2];
    bit         m_win  [2];
    bit         m_fav  [2];
    bit         m_owner[2];
    logic [3:0] m_q    [2];

    always @(posedge sclk or negedge srst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!srst_n) begin
                m_age[i]   <= 0;
                m_win[i]   <= 1'b0;
                m_fav[i]   <= 1'b0;
                m_owner[i] <= 1'b0;
                m_q[i]     <= 4'h0;
            end else if (m_age[i] == 0) begin
                if (sReq != 2'b00) begin
                    m_win[i] <= (sReq == 2'b11) ? m_fav[i] : (sReq == 2'b10);
                    m_age[i] <= 1;
                end
            end else begin
                if (m_age[i] == 1) begin
                    m_q[i]     <= m_win[i] ? sDat1 : sDat0;
                    m_owner[i] <= m_win[i];
                end
                if (m_age[i] >= 2 + m_lock[i]) begin
                    m_age[i] <= 0;
                    m_fav[i] <= !m_win[i];
                end else begin
                    m_age[i] <= m_age[i] + 1;
                end
            end
        end
    end

    // Packed {gnt, ack, q, owner, busy} expected from the model.
    function automatic logic [9:0] model_out(input int i);
        logic [1:0] sel;
        sel = m_win[i] ? 2'b10 : 2'b01;
        return {(m_age[i] == 1) ? sel : 2'b00,
                (m_age[i] == 2) ? sel : 2'b00,
                m_q[i], m_owner[i], (m_age[i] != 0)};
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic drain();
        sReq = 2'b00;
        step(8);
    endtask

    // Short reset pulse in the low clock phase; FSM restarts in IDLE.
    task automatic pulse_reset();
        #1 srst_n = 1'b0;
        #1 srst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [9:0] obs;
        sReq  = 2'b01;
        sDat0 = 4'h7;
        step(2);                         // dut_a in ACK, q = 7
        #2 srst_n = 1'b0;
        #1;
        obs = {a_gnt, a_ack, a_q, a_owner, a_busy};
        checks++;
        if (obs !== 10'h000) begin
            errors++;
            $display("FAIL reset_async_a: got %h expected 000", obs);
        end
        obs = {b_gnt, b_ack, b_q, b_owner, b_busy};
        checks++;
        if (obs !== 10'h000) begin
            errors++;
            $display("FAIL reset_async_b: got %h expected 000", obs);
        end
        sReq = 2'b00;
        #1 srst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1);
            checks++;
            if ({a_q, a_busy, b_q, b_busy} !== 10'h000) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: got q_a=%h busy_a=%b q_b=%h busy_b=%b expected all 0",
                         k, a_q, a_busy, b_q, b_busy);
            end
        end
    endtask

    task automatic test_single();
        logic [5:0] exp_a [5];
        exp_a = '{6'b01_00_0_1, 6'b00_01_0_1, 6'b00_00_0_1, 6'b00_00_0_1, 6'b00_00_0_0};
        drain();
        sReq  = 2'b01;
        sDat0 = 4'hA;
        sDat1 = 4'h6;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            if (k == 2) begin
                checks++;
                if (a_q !== 4'hA) begin
                    errors++;
                    $display("FAIL single_q: got %h expected a", a_q);
                end
                sReq = 2'b00;            // requester drops after its ack
            end
            checks++;
            if ({a_gnt, a_ack, a_owner, a_busy} !== exp_a[k-1]) begin
                errors++;
                $display("FAIL single cyc+%0d: got gnt/ack/owner/busy=%b expected %b",
                         k, {a_gnt, a_ack, a_owner, a_busy}, exp_a[k-1]);
            end
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_gnt;
        logic [3:0] exp_q;
        drain();
        pulse_reset();                  // pointer back to requester 0
        sReq  = 2'b11;
        sDat0 = 4'h3;
        sDat1 = 4'hC;
        for (int k = 1; k <= 15; k++) begin
            step(1);
            exp_gnt = (k % 5 != 1) ? 2'b00 : (((k / 5) % 2 == 0) ? 2'b01 : 2'b10);
            exp_q   = (k < 2) ? 4'h0 : ((((k - 2) / 5) % 2 == 0) ? 4'h3 : 4'hC);
            checks++;
            if ({a_gnt, a_q} !== {exp_gnt, exp_q}) begin
                errors++;
                $display("FAIL contention cyc+%0d: got gnt=%b q=%h expected gnt=%b q=%h",
                         k, a_gnt, a_q, exp_gnt, exp_q);
            end
        end
    endtask

    task automatic test_req_drop();
        drain();
        sReq  = 2'b10;
        sDat1 = 4'h5;
        sDat0 = 4'h9;
        step(1);
        checks++;
        if (a_gnt !== 2'b10) begin
            errors++;
            $display("FAIL drop_gnt: got %b expected 10", a_gnt);
        end
        sReq = 2'b00;                    // drop during GRANT
        step(1);
        checks++;
        if ({a_q, a_ack, a_owner} !== {4'h5, 2'b10, 1'b1}) begin
            errors++;
            $display("FAIL drop_ack: got q=%h ack=%b owner=%b expected q=5 ack=10 owner=1",
                     a_q, a_ack, a_owner);
        end
    endtask

    task automatic test_lock0();
        logic [2:0] exp;
        drain();
        sReq  = 2'b01;
        sDat0 = 4'h9;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            exp = {(k % 3 == 1) ? 2'b01 : 2'b00, k % 3 != 0};
            checks++;
            if ({b_gnt, b_busy} !== exp) begin
                errors++;
                $display("FAIL lock0 cyc+%0d: got gnt/busy=%b expected %b", k, {b_gnt, b_busy}, exp);
            end
        end
        checks++;
        if (b_q !== 4'h9) begin
            errors++;
            $display("FAIL lock0_q: got %h expected 9", b_q);
        end
    endtask

    task automatic test_reset_in_grant();
        drain();
        pulse_reset();
        sReq  = 2'b01;
        sDat0 = 4'hF;
        step(1);
        checks++;
        if (a_gnt !== 2'b01) begin
            errors++;
            $display("FAIL rgrant_gnt: got %b expected 01", a_gnt);
        end
        #2 srst_n = 1'b0;
        sReq = 2'b00;
        #1 srst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1);
            checks++;
            if ({a_q, a_ack, b_q, b_ack} !== 12'h000) begin
                errors++;
                $display("FAIL rgrant_abort cyc%0d: got q_a=%h ack_a=%b q_b=%h ack_b=%b expected all 0",
                         k, a_q, a_ack, b_q, b_ack);
            end
        end
    endtask

    task automatic test_random();
        logic [9:0] exp;
        drain();
        pulse_reset();
        for (int k = 0; k < 3000; k++) begin
            step(1);
            exp = model_out(0);
            checks++;
            if ({a_gnt, a_ack, a_q, a_owner, a_busy} !== exp) begin
                errors++;
                $display("FAIL random_a cyc%0d: got %b expected %b",
                         k, {a_gnt, a_ack, a_q, a_owner, a_busy}, exp);
            end
            exp = model_out(1);
            checks++;
            if ({b_gnt, b_ack, b_q, b_owner, b_busy} !== exp) begin
                errors++;
                $display("FAIL random_b cyc%0d: got %b expected %b",
                         k, {b_gnt, b_ack, b_q, b_owner, b_busy}, exp);
            end
            if ($urandom_range(0, 249) == 0) pulse_reset();
            sReq  = 2'($urandom);
            sDat0 = 4'($urandom);
            sDat1 = 4'($urandom);
        end
    endtask

    initial begin
        step(2);
        srst_n = 1'b1;
        step(1);
        test_reset();
        test_contention();
        test_single();
        test_req_drop();
        test_lock0();
        test_reset_in_grant();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
